// File: rtl/versatile_mem_ctrl_egress_arb_pkg.sv
// Shared defines for the SDRAM-side egress arbiter and the wishbone bridge.
// Command word layout, burst encodings and arbiter FSM states.
package versatile_mem_ctrl_egress_arb_pkg;

  localparam int ADR_HI = 35;
  localparam int ADR_LO = 6;
  localparam int WE_BIT = 5;
  localparam int BTE_HI = 4;
  localparam int BTE_LO = 3;
  localparam int CTI_HI = 2;
  localparam int CTI_LO = 0;

  localparam logic [2:0] classic    = 3'b000;
  localparam logic [2:0] endofburst = 3'b111;

  localparam logic [1:0] linear_burst = 2'b00;
  localparam logic [1:0] wrap4        = 2'b01;
  localparam logic [1:0] wrap8        = 2'b10;
  localparam logic [1:0] wrap16       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR,
    S_CMD,
    S_WPOP,
    S_WDAT,
    S_RWAIT,
    S_DONE
  } state_t;

  function automatic logic [4:0] burst_len(
    input logic [2:0] cti,
    input logic [1:0] bte,
    input logic [4:0] lin
  );
    logic [4:0] len;
    len = 5'd1;
    if (cti != classic && cti != endofburst) begin
      unique case (bte)
        linear_burst: len = lin;
        wrap4:        len = 5'd4;
        wrap8:        len = 5'd8;
        default:      len = 5'd16;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/versatile_mem_ctrl_egress_arb_rr_pick.sv
// Round-robin finder: first set request at or after ptr, one-hot grant.
// Pure combinational; ptr must be below n.
module versatile_mem_ctrl_egress_arb_rr_pick #(
  parameter int n = 3
) (
  input  logic [0:n-1] req,
  input  logic [1:0]   ptr,
  output logic [0:n-1] gnt,
  output logic [1:0]   idx,
  output logic         any
);

  int         j;
  logic [1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    k   = '0;
    for (int i = 0; i < n; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      k = j[1:0];
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/versatile_mem_ctrl_egress_arb.sv
// SDRAM-side egress arbiter: pops one command per port round-robin,
// issues the burst, streams write data or steers read data to ingress.
module versatile_mem_ctrl_egress_arb
  import versatile_mem_ctrl_egress_arb_pkg::*;
#(
  parameter int nr_of_wb_ports = 3,
  parameter int linear_len     = 8
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst,
  input  logic [0:nr_of_wb_ports-1] sdram_fifo_empty,
  output logic [0:nr_of_wb_ports-1] sdram_fifo_rd,
  input  logic [35:0]               sdram_dat_o,
  output logic [0:nr_of_wb_ports-1] sdram_fifo_wr,
  output logic [31:0]               sdram_dat_i,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_we,
  output logic [29:0]               cmd_adr,
  output logic [4:0]                cmd_len,
  output logic [1:0]                cmd_bte,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [31:0]               wr_dat,
  output logic [3:0]                wr_sel,
  input  logic                      rd_valid,
  input  logic [31:0]               rd_dat
);

  localparam logic [4:0] lin_len  = 5'(linear_len);
  localparam logic [1:0] last_prt = 2'(nr_of_wb_ports - 1);

  state_t state, state_nxt;

  logic [1:0]  ptr;
  logic [1:0]  port;
  logic [4:0]  cnt;
  logic        wdat_first;
  logic [31:0] wdat_q;
  logic [3:0]  wsel_q;
  logic [4:0]  len_nxt;

  logic [0:nr_of_wb_ports-1] pick_gnt;
  logic [1:0]                pick_idx;
  logic                      pick_any;
  logic [0:nr_of_wb_ports-1] port_oh;
  logic                      port_empty;

  versatile_mem_ctrl_egress_arb_rr_pick #(
    .n(nr_of_wb_ports)
  ) u_rr_pick (
    .req(~sdram_fifo_empty),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    port_oh       = '0;
    port_oh[port] = 1'b1;
  end

  assign port_empty = sdram_fifo_empty[port];
  assign len_nxt    = burst_len(sdram_dat_o[CTI_HI:CTI_LO],
                                sdram_dat_o[BTE_HI:BTE_LO], lin_len);

  // First WDAT cycle forwards the RAM output; later cycles hold the copy.
  assign wr_dat = wdat_first ? sdram_dat_o[35:4] : wdat_q;
  assign wr_sel = wdat_first ? sdram_dat_o[3:0]  : wsel_q;

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    sdram_fifo_rd = '0;
    sdram_fifo_wr = '0;
    sdram_dat_i   = '0;
    cmd_valid     = 1'b0;
    wr_valid      = 1'b0;
    if (!sdram_rst) begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            sdram_fifo_rd = pick_gnt;
            state_nxt     = S_ADR;
          end
        end
        S_ADR: state_nxt = S_CMD;
        S_CMD: begin
          cmd_valid = 1'b1;
          if (cmd_ready) state_nxt = cmd_we ? S_WPOP : S_RWAIT;
        end
        S_WPOP: begin
          if (!port_empty) begin
            sdram_fifo_rd = port_oh;
            state_nxt     = S_WDAT;
          end
        end
        S_WDAT: begin
          wr_valid = 1'b1;
          if (wr_ready) state_nxt = (cnt == 5'd1) ? S_DONE : S_WPOP;
        end
        S_RWAIT: begin
          if (rd_valid) begin
            sdram_fifo_wr = port_oh;
            sdram_dat_i   = rd_dat;
            if (cnt == 5'd1) state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      ptr        <= '0;
      port       <= '0;
      cnt        <= '0;
      cmd_we     <= 1'b0;
      cmd_adr    <= '0;
      cmd_len    <= '0;
      cmd_bte    <= '0;
      wdat_first <= 1'b0;
      wdat_q     <= '0;
      wsel_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (pick_any) port <= pick_idx;
        S_ADR: begin
          cmd_adr <= sdram_dat_o[ADR_HI:ADR_LO];
          cmd_we  <= sdram_dat_o[WE_BIT];
          cmd_bte <= sdram_dat_o[BTE_HI:BTE_LO];
          cmd_len <= len_nxt;
          cnt     <= len_nxt;
        end
        S_WPOP: wdat_first <= !port_empty;
        S_WDAT: begin
          if (wdat_first) begin
            wdat_q <= sdram_dat_o[35:4];
            wsel_q <= sdram_dat_o[3:0];
          end
          wdat_first <= 1'b0;
          if (wr_ready) cnt <= cnt - 5'd1;
        end
        S_RWAIT: if (rd_valid) cnt <= cnt - 5'd1;
        S_DONE:  ptr <= (port == last_prt) ? 2'd0 : port + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_versatile_mem_ctrl_egress_arb.sv
// Bench for the egress arbiter: FIFO/SDRAM environment model plus a
// transaction-level reference built from the command-word rules.
module tb_versatile_mem_ctrl_egress_arb;

  localparam int N   = 3;
  localparam int LIN = 8;

  logic           sdram_clk = 1'b0;
  logic           sdram_rst;
  logic [0:N-1]   sdram_fifo_empty;
  logic [0:N-1]   sdram_fifo_rd;
  logic [35:0]    sdram_dat_o;
  logic [0:N-1]   sdram_fifo_wr;
  logic [31:0]    sdram_dat_i;
  logic           cmd_valid, cmd_ready, cmd_we;
  logic [29:0]    cmd_adr;
  logic [4:0]     cmd_len;
  logic [1:0]     cmd_bte;
  logic           wr_valid, wr_ready;
  logic [31:0]    wr_dat;
  logic [3:0]     wr_sel;
  logic           rd_valid;
  logic [31:0]    rd_dat;

  versatile_mem_ctrl_egress_arb #(
    .nr_of_wb_ports(N),
    .linear_len(LIN)
  ) dut (
    .sdram_clk(sdram_clk),
    .sdram_rst(sdram_rst),
    .sdram_fifo_empty(sdram_fifo_empty),
    .sdram_fifo_rd(sdram_fifo_rd),
    .sdram_dat_o(sdram_dat_o),
    .sdram_fifo_wr(sdram_fifo_wr),
    .sdram_dat_i(sdram_dat_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we(cmd_we),
    .cmd_adr(cmd_adr),
    .cmd_len(cmd_len),
    .cmd_bte(cmd_bte),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_dat(wr_dat),
    .wr_sel(wr_sel),
    .rd_valid(rd_valid),
    .rd_dat(rd_dat)
  );

  always #5 sdram_clk = ~sdram_clk;

  int checks   = 0;
  int failures = 0;

  logic [35:0] q    [N][$];
  logic [35:0] feed [N][$];
  int          pend;

  int cmd_pct, wr_pct, rd_pct, feed_pct, cmd_stall, stall_cnt;
  bit stray, rd_seq;

  bit          m_busy, m_we, m_acc;
  int          m_ptr, m_port, m_len, m_pops, m_beats, m_pushes;
  logic [29:0] m_adr;
  logic [1:0]  m_bte;
  logic [35:0] m_wexp [$];

  int          served [$];
  int          pop_cnt [N];
  int          push_cnt [N];
  logic [31:0] push_log [$];
  int          beats_total, stall_seen;
  logic [29:0] acc_adr;
  logic [4:0]  acc_len;
  logic        acc_we;
  logic [31:0] last_wr_dat;
  logic [3:0]  last_wr_sel;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] cti, input logic [1:0] bte);
    if (cti == 3'd0 || cti == 3'd7) return 1;
    case (bte)
      2'd0:    return LIN;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [0:N-1] onehot(input int p);
    logic [0:N-1] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic bit all_idle();
    for (int p = 0; p < N; p++)
      if (q[p].size() != 0 || feed[p].size() != 0) return 0;
    return !m_busy && pend < 0;
  endfunction

  task automatic add_cmd(input int p, input bit we, input logic [1:0] bte,
                         input logic [2:0] cti, input logic [29:0] adr,
                         input bit direct, input int n_direct_data);
    logic [35:0] w;
    int          n;
    w = {adr, we, bte, cti};
    if (direct) q[p].push_back(w);
    else        feed[p].push_back(w);
    if (we) begin
      n = len_of(cti, bte);
      for (int i = 0; i < n; i++) begin
        w = {$urandom, 4'($urandom_range(15))};
        if (direct && i < n_direct_data) q[p].push_back(w);
        else                             feed[p].push_back(w);
      end
    end
  endtask

  task automatic finish_txn();
    m_busy = 1'b0;
    m_ptr  = (m_port + 1) % N;
  endtask

  task automatic observe();
    int          npop, npush, p, e;
    logic [35:0] w;
    npop  = $countones(sdram_fifo_rd);
    npush = $countones(sdram_fifo_wr);
    chk("rd_onehot", npop <= 1, 1);
    chk("rd_wr_excl", (npop != 0) && (npush != 0), 0);

    if (m_busy && m_acc && !m_we && rd_valid)
      chk("push_on_rdv", npush, 1);
    if (npush != 0) begin
      chk("push_phase", m_busy && m_acc && !m_we, 1);
      chk("push_port", sdram_fifo_wr, onehot(m_port));
      chk("push_dat", sdram_dat_i, rd_dat);
      for (int i = 0; i < N; i++) if (sdram_fifo_wr[i]) push_cnt[i]++;
      push_log.push_back(sdram_dat_i);
      m_pushes++;
      if (m_busy && m_pushes == m_len) finish_txn();
    end

    if (wr_valid)
      chk("wr_phase", m_busy && m_we && m_acc && m_pops == m_beats + 1, 1);
    if (wr_valid && wr_ready) begin
      w = (m_wexp.size() > 0) ? m_wexp.pop_front() : 36'hx;
      chk("wr_dat", wr_dat, w[35:4]);
      chk("wr_sel", wr_sel, w[3:0]);
      last_wr_dat = wr_dat;
      last_wr_sel = wr_sel;
      beats_total++;
      m_beats++;
      if (m_busy && m_beats == m_len) finish_txn();
    end

    if (npop == 1) begin
      p = 0;
      for (int i = 0; i < N; i++) if (sdram_fifo_rd[i]) p = i;
      chk("pop_nonempty", q[p].size() > 0, 1);
      w = (q[p].size() > 0) ? q[p][0] : 36'h0;
      if (!m_busy) begin
        e = -1;
        for (int i = 0; i < N; i++)
          if (e < 0 && q[(m_ptr + i) % N].size() > 0) e = (m_ptr + i) % N;
        chk("rr_port", p, e);
        m_busy   = 1'b1;
        m_acc    = 1'b0;
        m_port   = p;
        m_we     = w[5];
        m_adr    = w[35:6];
        m_bte    = w[4:3];
        m_len    = len_of(w[2:0], w[4:3]);
        m_pops   = 0;
        m_beats  = 0;
        m_pushes = 0;
        m_wexp.delete();
        served.push_back(p);
      end else begin
        chk("data_pop_ok", m_we && m_acc && p == m_port &&
            m_pops == m_beats && m_pops < m_len, 1);
        m_wexp.push_back(w);
        m_pops++;
      end
      pop_cnt[p]++;
      pend = p;
    end

    if (cmd_valid) begin
      chk("cmd_phase", m_busy && !m_acc, 1);
      chk("cmd_adr", cmd_adr, m_adr);
      chk("cmd_we", cmd_we, m_we);
      chk("cmd_bte", cmd_bte, m_bte);
      chk("cmd_len", cmd_len, m_len);
      if (cmd_ready) begin
        m_acc     = 1'b1;
        stall_cnt = 0;
        acc_adr   = cmd_adr;
        acc_len   = cmd_len;
        acc_we    = cmd_we;
      end else begin
        stall_cnt++;
        stall_seen++;
      end
    end
  endtask

  task automatic step();
    @(negedge sdram_clk);
    if (pend >= 0) begin
      if (q[pend].size() > 0) sdram_dat_o = q[pend].pop_front();
      pend = -1;
    end
    for (int p = 0; p < N; p++)
      if (feed[p].size() > 0 && $urandom_range(99) < feed_pct)
        q[p].push_back(feed[p].pop_front());
    for (int p = 0; p < N; p++) sdram_fifo_empty[p] = (q[p].size() == 0);
    cmd_ready = (stall_cnt >= cmd_stall) && ($urandom_range(99) < cmd_pct);
    wr_ready  = ($urandom_range(99) < wr_pct);
    rd_dat    = rd_seq ? 32'(m_pushes + 1) : $urandom;
    if (m_busy && m_acc && !m_we)
      rd_valid = (m_pushes < m_len) && ($urandom_range(99) < rd_pct);
    else
      rd_valid = stray && ($urandom_range(1) == 1);
    #1;
    observe();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, all_idle(), 1);
    step();
    step();
  endtask

  task automatic clear_stats();
    served.delete();
    push_log.delete();
    for (int p = 0; p < N; p++) begin
      pop_cnt[p]  = 0;
      push_cnt[p] = 0;
    end
    beats_total = 0;
    stall_seen  = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {sdram_fifo_rd, sdram_fifo_wr}, 0);
    chk({tag, "_cmd"}, {cmd_valid, cmd_we, cmd_adr, cmd_len, cmd_bte}, 0);
    chk({tag, "_wr"}, {wr_valid, wr_dat, wr_sel}, 0);
    chk({tag, "_dat_i"}, sdram_dat_i, 0);
  endtask

  task automatic set_rates(input int c, input int w, input int r, input int f);
    cmd_pct  = c;
    wr_pct   = w;
    rd_pct   = r;
    feed_pct = f;
  endtask

  int fair_exp [6] = '{0, 1, 2, 0, 1, 2};
  int n_wait;

  initial begin
    sdram_rst        = 1'b1;
    sdram_fifo_empty = '1;
    sdram_dat_o      = '0;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    rd_valid         = 1'b0;
    rd_dat           = '0;
    pend             = -1;
    m_busy           = 1'b0;
    m_ptr            = 0;
    stall_cnt        = 0;
    cmd_stall        = 0;
    stray            = 1'b0;
    rd_seq           = 1'b0;
    set_rates(100, 100, 100, 100);
    clear_stats();

    repeat (2) @(negedge sdram_clk);
    #1;
    chk_zero("reset");
    @(negedge sdram_clk);
    sdram_rst = 1'b0;

    // fairness from pointer 0, refilled once
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < N; p++)
        add_cmd(p, 1'b0, 2'b00, 3'b000, 30'($urandom), 1'b1, 0);
      run_idle("fair", 300);
    end
    chk("fair_cnt", served.size(), 6);
    for (int i = 0; i < served.size() && i < 6; i++)
      chk("fair_order", served[i], fair_exp[i]);

    // single write on port 1
    clear_stats();
    q[1].push_back({30'h100, 1'b1, 2'b00, 3'b000});
    q[1].push_back({32'hDEADBEEF, 4'hF});
    run_idle("single", 200);
    chk("single_pops", {pop_cnt[0], pop_cnt[1], pop_cnt[2]}, {32'd0, 32'd2, 32'd0});
    chk("single_cmd", {acc_we, acc_adr, acc_len}, {1'b1, 30'h100, 5'd1});
    chk("single_wr", {last_wr_dat, last_wr_sel}, {32'hDEADBEEF, 4'hF});
    chk("single_beats", beats_total, 1);

    // wrap4 read on port 0 with sequential return data
    clear_stats();
    rd_seq = 1'b1;
    add_cmd(0, 1'b0, 2'b01, 3'b010, 30'h2A5, 1'b1, 0);
    run_idle("wrap4", 200);
    rd_seq = 1'b0;
    chk("wrap4_len", acc_len, 4);
    chk("wrap4_push", {push_cnt[0], push_cnt[1], push_cnt[2]}, {32'd4, 32'd0, 32'd0});
    chk("wrap4_cnt", push_log.size(), 4);
    for (int i = 0; i < push_log.size() && i < 4; i++)
      chk("wrap4_dat", push_log[i], i + 1);

    // backpressure: stalled command, toggling wr_ready, trickling data
    clear_stats();
    cmd_stall = 5;
    set_rates(100, 50, 100, 20);
    add_cmd(2, 1'b1, 2'b10, 3'b010, 30'h3FF_0000, 1'b1, 2);
    run_idle("bp", 1000);
    cmd_stall = 0;
    set_rates(100, 100, 100, 100);
    chk("bp_len", acc_len, 8);
    chk("bp_beats", beats_total, 8);
    chk("bp_pops", pop_cnt[2], 9);
    chk("bp_stall", stall_seen >= 5, 1);

    // stray rd_valid while idle
    clear_stats();
    stray = 1'b1;
    repeat (12) step();
    stray = 1'b0;
    chk("stray_push", push_cnt[0] + push_cnt[1] + push_cnt[2], 0);

    // linear write on port 0
    clear_stats();
    add_cmd(0, 1'b1, 2'b00, 3'b001, 30'($urandom), 1'b1, 8);
    run_idle("linear", 300);
    chk("linear_len", acc_len, LIN);
    chk("linear_pops", pop_cnt[0], LIN + 1);

    // reset in the middle of a write burst on port 2 (pointer is 1 here)
    clear_stats();
    add_cmd(2, 1'b1, 2'b01, 3'b010, 30'h123, 1'b1, 4);
    n_wait = 0;
    while (!wr_valid && n_wait < 100) begin
      step();
      n_wait++;
    end
    chk("rst_reach_wdat", wr_valid, 1);
    #2;
    sdram_rst = 1'b1;
    #1;
    chk_zero("midrst");
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      feed[p].delete();
    end
    sdram_fifo_empty = '1;
    pend      = -1;
    m_busy    = 1'b0;
    m_ptr     = 0;
    stall_cnt = 0;
    m_wexp.delete();
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    clear_stats();
    for (int p = 0; p < N; p++)
      add_cmd(p, 1'b0, 2'b00, 3'b111, 30'($urandom), 1'b1, 0);
    run_idle("postrst", 300);
    chk("postrst_first", (served.size() > 0) ? served[0] : -1, 0);
    chk("postrst_cnt", served.size(), 3);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      set_rates($urandom_range(100, 30), $urandom_range(100, 30),
                $urandom_range(100, 30), $urandom_range(100, 20));
      cmd_stall = $urandom_range(3);
      stray     = ($urandom_range(1) == 1);
      for (int p = 0; p < N; p++) begin
        int nc;
        nc = $urandom_range(2);
        for (int c = 0; c < nc; c++)
          add_cmd(p, 1'($urandom_range(1)), 2'($urandom_range(3)),
                  3'($urandom_range(7)), 30'($urandom), 1'b0, 0);
      end
      run_idle("rand", 4000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
